// File: rtl/seq_perceptron_pkg.sv
// Shared state type, config encodings and reset defaults for the sequential perceptron.
package seq_perceptron_pkg;

  localparam int N_FEAT_DEF  = 2;
  localparam int FEAT_W_DEF  = 4;
  localparam int SHIFT_W_DEF = 3;
  localparam int SUM_W_DEF   = 12;
  localparam int N_CLASS_DEF = 10;
  localparam int CLASS_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_MATCH,
    ST_DONE
  } state_e;

  localparam logic CFG_SEL_SHIFT = 1'b0;
  localparam logic CFG_SEL_TMPL  = 1'b1;

  localparam int DEFAULT_SHIFT0 = 1;
  localparam int DEFAULT_SHIFT1 = 3;
  localparam int N_DEFAULT_TMPL = 10;

  function automatic int default_shift(input int idx);
    case (idx)
      0:       return DEFAULT_SHIFT0;
      1:       return DEFAULT_SHIFT1;
      default: return 0;
    endcase
  endfunction

  // Template sums for the shapes the fixed classifier used to recognise.
  function automatic int default_template(input int idx);
    case (idx)
      0:       return 32;
      1:       return 2;
      2:       return 20;
      3:       return 34;
      4:       return 6;
      5:       return 28;
      6:       return 40;
      7:       return 4;
      8:       return 64;
      9:       return 26;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/perceptron_template_table.sv
// Programmable table of {valid, sum} templates with one write port and one read port.
module perceptron_template_table
  import seq_perceptron_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int SUM_W   = SUM_W_DEF,
  parameter int CLASS_W = CLASS_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [CLASS_W-1:0] waddr,
  input  logic [SUM_W:0]     wdata,
  input  logic [CLASS_W-1:0] raddr,
  output logic [SUM_W:0]     rdata
);

  logic [SUM_W:0] entry_q [N_CLASS];
  logic [SUM_W:0] entry_d [N_CLASS];

  always_comb begin
    for (int i = 0; i < N_CLASS; i++) begin
      entry_d[i] = entry_q[i];
      if (we && waddr == CLASS_W'(i)) begin
        entry_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CLASS; i++) begin
        entry_q[i] <= {1'(i < N_DEFAULT_TMPL), SUM_W'(default_template(i))};
      end
    end else begin
      for (int i = 0; i < N_CLASS; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (raddr == CLASS_W'(i)) begin
        rdata = entry_q[i];
      end
    end
  end

endmodule

// File: rtl/seq_perceptron.sv
// Sequential perceptron: accumulates shift-weighted features, then scans templates for an exact match.
module seq_perceptron
  import seq_perceptron_pkg::*;
#(
  parameter int N_FEAT  = N_FEAT_DEF,
  parameter int FEAT_W  = FEAT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int SUM_W   = SUM_W_DEF,
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int CLASS_W = CLASS_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic                     cfg_sel,
  input  logic [CLASS_W-1:0]       cfg_addr,
  input  logic [SUM_W:0]           cfg_data,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_hit,
  output logic                     out_sat,
  output logic [SUM_W-1:0]         out_sum
);

  localparam int FIDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int WIDE_W = SUM_W + 8;

  state_e                   state_q, state_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic                     sat_q, sat_d;
  logic                     hit_q, hit_d;
  logic                     cfg_err_q, cfg_err_d;
  logic [CLASS_W-1:0]       idx_q, idx_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic [FIDX_W-1:0]        fidx_q, fidx_d;
  logic [SHIFT_W-1:0]       shift_q [N_FEAT];
  logic [SHIFT_W-1:0]       shift_d [N_FEAT];

  logic                     cfg_open, addr_ok, cfg_accept, tmpl_we;
  logic [FEAT_W-1:0]        cur_feat;
  logic [SHIFT_W-1:0]       cur_shift;
  logic [WIDE_W-1:0]        wide_sum;
  logic [SUM_W:0]           rd_entry;

  perceptron_template_table #(
    .N_CLASS (N_CLASS),
    .SUM_W   (SUM_W),
    .CLASS_W (CLASS_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tmpl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_q),
    .rdata (rd_entry)
  );

  // Config only lands while no vector is in flight, so a running scan sees a frozen table.
  always_comb begin
    cfg_open   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    addr_ok    = (cfg_sel == CFG_SEL_SHIFT) ? (int'(cfg_addr) < N_FEAT)
                                            : (int'(cfg_addr) < N_CLASS);
    cfg_accept = cfg_we && cfg_open && addr_ok;
    cfg_err_d  = cfg_we && !(cfg_open && addr_ok);
    tmpl_we    = cfg_accept && (cfg_sel == CFG_SEL_TMPL);
    for (int i = 0; i < N_FEAT; i++) begin
      shift_d[i] = shift_q[i];
      if (cfg_accept && cfg_sel == CFG_SEL_SHIFT && cfg_addr == CLASS_W'(i)) begin
        shift_d[i] = cfg_data[SHIFT_W-1:0];
      end
    end
  end

  always_comb begin
    cur_feat  = '0;
    cur_shift = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (fidx_q == FIDX_W'(i)) begin
        cur_feat  = feat_q[i*FEAT_W +: FEAT_W];
        cur_shift = shift_q[i];
      end
    end
    wide_sum = WIDE_W'(sum_q) + (WIDE_W'(cur_feat) << cur_shift);
  end

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    idx_d   = idx_q;
    fidx_d  = fidx_q;
    class_d = class_q;
    hit_d   = hit_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          feat_d  = in_feat;
          sum_d   = '0;
          sat_d   = 1'b0;
          idx_d   = '0;
          fidx_d  = '0;
          class_d = '0;
          hit_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (wide_sum > WIDE_W'({SUM_W{1'b1}})) begin
          sum_d = '1;
          sat_d = 1'b1;
        end else begin
          sum_d = wide_sum[SUM_W-1:0];
        end
        if (fidx_q == FIDX_W'(N_FEAT - 1)) begin
          idx_d   = '0;
          state_d = ST_MATCH;
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
      ST_MATCH: begin
        if (rd_entry[SUM_W] && rd_entry[SUM_W-1:0] == sum_q) begin
          class_d = idx_q;
          hit_d   = 1'b1;
          state_d = ST_DONE;
        end else if (idx_q == CLASS_W'(N_CLASS - 1)) begin
          class_d = feat_q[(N_FEAT-1)*FEAT_W +: CLASS_W];
          hit_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      feat_q    <= '0;
      sum_q     <= '0;
      sat_q     <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      class_q   <= '0;
      fidx_q    <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) begin
        shift_q[i] <= SHIFT_W'(default_shift(i));
      end
    end else begin
      state_q   <= state_d;
      feat_q    <= feat_d;
      sum_q     <= sum_d;
      sat_q     <= sat_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      class_q   <= class_d;
      fidx_q    <= fidx_d;
      cfg_err_q <= cfg_err_d;
      for (int i = 0; i < N_FEAT; i++) begin
        shift_q[i] <= shift_d[i];
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_class = out_valid ? class_q : '0;
  assign out_hit   = out_valid & hit_q;
  assign out_sat   = out_valid & sat_q;
  assign out_sum   = out_valid ? sum_q : '0;
  assign cfg_err   = cfg_err_q;

endmodule
